// File: rtl/mem_delayed_ctrl.sv
// mem_delayed_ctrl: single-port 32-bit word memory with a fixed access latency
// and one outstanding request.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   mem_addr     byte address of the processor request (bits [1:0] ignored)
//   mem_rd_req   read request pulse
//   mem_wr_req   write request pulse (wins over a simultaneous read)
//   mem_wr_data  write data, sampled with mem_wr_req
//   mem_rd_data  read data, valid in the mem_ack cycle, held otherwise
//   mem_ack      one-cycle completion pulse, LATENCY cycles after acceptance
//   mem_busy     request in flight; new requests are ignored while high
//   load_en      backdoor write enable, honoured on every edge (even in reset)
//   load_addr    backdoor byte address
//   load_data    backdoor write data
module mem_delayed_ctrl #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_ack,
  output logic        mem_busy,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned Aw    = $clog2(DEPTH);
  localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hold_q;
  logic        is_rd_q;
  logic [31:0] rd_data_q;
  logic [31:0] mem_q [DEPTH];

  logic [Aw-1:0] req_idx, load_idx;
  logic          req_in_range, load_in_range;
  logic          accept, wr_accept;

  // Out-of-range means any word-index bit at or above DEPTH is set.
  assign req_idx       = mem_addr[Aw+1:2];
  assign load_idx      = load_addr[Aw+1:2];
  assign req_in_range  = (mem_addr[31:Aw+2] == '0);
  assign load_in_range = (load_addr[31:Aw+2] == '0);

  // Acceptance is possible in IDLE and in the ACK cycle; only WAIT blocks.
  assign accept    = rst && (state_q != StWait) && (mem_rd_req || mem_wr_req);
  assign wr_accept = accept && mem_wr_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StAck: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = LatM1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StAck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_ack     = (state_q == StAck);
  assign mem_busy    = (state_q == StWait);
  assign mem_rd_data = (mem_ack && is_rd_q) ? hold_q : rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= mem_rd_data;
    end
  end

  // Read data is captured at acceptance so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_rd_q <= ~mem_wr_req;
      hold_q  <= (~mem_wr_req && req_in_range) ? mem_q[req_idx] : '0;
    end
  end

  // Processor write is issued last so it wins over a same-index backdoor load.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem_q[load_idx] <= load_data;
    end
    if (wr_accept && req_in_range) begin
      mem_q[req_idx] <= mem_wr_data;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[1:0], load_addr[1:0]};

endmodule

// File: tb/tb_mem_delayed_ctrl.sv
// Bench for mem_delayed_ctrl: a LATENCY=4 and a LATENCY=1 instance share one
// stimulus stream; each is compared every cycle with a transaction-level model.
module tb_mem_delayed_ctrl;

  localparam int unsigned Depth = 64;
  localparam int unsigned Aw    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, wr, load_en;
  logic [31:0] addr, wdata, load_addr, load_data;
  logic [31:0] rdata4, rdata1;
  logic        ack4, ack1, busy4, busy1;

  int checks = 0;
  int errors = 0;

  mem_delayed_ctrl #(.DEPTH(Depth), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_rd_req(rd), .mem_wr_req(wr),
    .mem_wr_data(wdata), .mem_rd_data(rdata4), .mem_ack(ack4), .mem_busy(busy4),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  mem_delayed_ctrl #(.DEPTH(Depth), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_rd_req(rd), .mem_wr_req(wr),
    .mem_wr_data(wdata), .mem_rd_data(rdata1), .mem_ack(ack1), .mem_busy(busy1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Model: per instance, memory image plus one pending transaction that
  // completes 'rem' cycles from now.
  logic [31:0] mm [2][Depth];
  bit          pend [2];
  int          rem  [2];
  bit          isrd [2];
  logic [31:0] data [2];
  logic [31:0] last [2];
  int          lat  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit          busy_now, ack_now, acc;
      logic [29:0] widx, lidx;
      logic [31:0] rd_val;
      busy_now = pend[k] && (rem[k] > 0);
      ack_now  = pend[k] && (rem[k] == 0);
      widx     = addr[31:2];
      lidx     = load_addr[31:2];
      rd_val   = (widx < 30'(Depth)) ? mm[k][widx[Aw-1:0]] : 32'h0;
      if (load_en && (lidx < 30'(Depth))) mm[k][lidx[Aw-1:0]] = load_data;
      if (!rst) begin
        pend[k] = 1'b0;
        last[k] = 32'h0;
      end else begin
        if (ack_now && isrd[k]) last[k] = data[k];
        acc = !busy_now && (rd || wr);
        if (acc) begin
          pend[k] = 1'b1;
          rem[k]  = lat[k] - 1;
          isrd[k] = !wr;
          if (wr) begin
            if (widx < 30'(Depth)) mm[k][widx[Aw-1:0]] = wdata;
          end else begin
            data[k] = rd_val;
          end
        end else if (pend[k]) begin
          if (rem[k] == 0) pend[k] = 1'b0;
          else rem[k]--;
        end
      end
    end
  endtask

  task automatic tick();
    bit          e_ack, e_busy;
    logic [31:0] e_rd;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      e_ack  = pend[k] && (rem[k] == 0);
      e_busy = pend[k] && (rem[k] > 0);
      e_rd   = (e_ack && isrd[k]) ? data[k] : last[k];
      if (k == 0) begin
        chk("m_ack4", 32'(ack4), 32'(e_ack));
        chk("m_busy4", 32'(busy4), 32'(e_busy));
        chk("m_rd4", rdata4, e_rd);
      end else begin
        chk("m_ack1", 32'(ack1), 32'(e_ack));
        chk("m_busy1", 32'(busy1), 32'(e_busy));
        chk("m_rd1", rdata1, e_rd);
      end
    end
  endtask

  task automatic pulse_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    tick();
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    lat[0] = 4; lat[1] = 1;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Preload every word during reset.
    for (int i = 0; i < int'(Depth); i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = (i == 0) ? 32'h0010_0093 : $urandom;
      tick();
    end
    load_en = 1'b0;
    tick();
    chk("rst_ack4", 32'(ack4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_rd4", rdata4, 32'h0);
    rst = 1'b1;
    tick();

    // Basic read with latency 4.
    pulse_req(1'b1, 1'b0, 32'h0, 32'h0);
    chk("p1_ack1", 32'(ack1), 32'd1);
    chk("p1_rd1", rdata1, 32'h0010_0093);
    chk("p1_busy1", 32'(busy1), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      chk("p1_busy", 32'(busy4), 32'd1);
      chk("p1_noack", 32'(ack4), 32'd0);
      tick();
    end
    chk("p1_ack", 32'(ack4), 32'd1);
    chk("p1_busy_ack", 32'(busy4), 32'd0);
    chk("p1_data", rdata4, 32'h0010_0093);
    tick();
    chk("p1_ack_end", 32'(ack4), 32'd0);

    // Write then back-to-back read issued in the ack cycle.
    pulse_req(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    tick(); tick(); tick();
    chk("p2_wack", 32'(ack4), 32'd1);
    pulse_req(1'b1, 1'b0, 32'h8, 32'h0);
    chk("p2_busy", 32'(busy4), 32'd1);
    tick(); tick(); tick();
    chk("p2_rack", 32'(ack4), 32'd1);
    chk("p2_data", rdata4, 32'hDEAD_BEEF);
    tick();

    // Request while busy is ignored.
    pulse_req(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    pulse_req(1'b1, 1'b0, 32'h4, 32'h0);
    chk("p3_busy", 32'(busy4), 32'd1);
    tick();
    chk("p3_ack", 32'(ack4), 32'd1);
    chk("p3_data", rdata4, 32'h0010_0093);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n += int'(ack4);
    end
    chk("p3_no_extra", 32'(n), 32'd0);

    // Read and write together: write wins, single ack.
    pulse_req(1'b1, 1'b1, 32'hC, 32'h5);
    n = int'(ack4);
    for (int c = 0; c < 6; c++) begin
      tick();
      n += int'(ack4);
    end
    chk("p4_one_ack", 32'(n), 32'd1);
    pulse_req(1'b1, 1'b0, 32'hC, 32'h0);
    tick(); tick(); tick();
    chk("p4_data", rdata4, 32'h5);
    tick();

    // Out-of-range read returns zero; out-of-range write must not alias word 0.
    pulse_req(1'b1, 1'b0, 32'(4 * Depth), 32'h0);
    tick(); tick(); tick();
    chk("p5_ack", 32'(ack4), 32'd1);
    chk("p5_data", rdata4, 32'h0);
    tick();
    pulse_req(1'b0, 1'b1, 32'(4 * Depth), 32'hFFFF_FFFF);
    for (int c = 0; c < 4; c++) tick();
    pulse_req(1'b1, 1'b0, 32'h0, 32'h0);
    tick(); tick(); tick();
    chk("p5_w0", rdata4, 32'h0010_0093);
    tick();

    // Reset while waiting aborts without ack.
    pulse_req(1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("p6_ack", 32'(ack4), 32'd0);
    chk("p6_busy", 32'(busy4), 32'd0);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n += int'(ack4);
    end
    chk("p6_no_ack", 32'(n), 32'd0);
    pulse_req(1'b1, 1'b0, 32'h8, 32'h0);
    tick(); tick(); tick();
    chk("p6_ack_full", 32'(ack4), 32'd1);
    chk("p6_data", rdata4, 32'hDEAD_BEEF);
    tick();

    // Latency 1: ack next cycle, never busy; request during reset is ignored.
    pulse_req(1'b1, 1'b0, 32'h0, 32'h0);
    chk("l1_ack", 32'(ack1), 32'd1);
    chk("l1_busy", 32'(busy1), 32'd0);
    chk("l1_data", rdata1, 32'h0010_0093);
    tick();
    chk("l1_ack_end", 32'(ack1), 32'd0);
    rst = 1'b0;
    pulse_req(1'b1, 1'b0, 32'h0, 32'h0);
    chk("l1_rst_ack", 32'(ack1), 32'd0);
    rst = 1'b1;
    tick(); tick(); tick(); tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r     = int'($urandom_range(0, 99));
      rd    = (r < 30);
      wr    = (r >= 20) && (r < 45);
      addr  = (32'($urandom_range(0, Depth + 3)) << 2) | 32'($urandom_range(0, 3));
      if (r == 99) addr = $urandom;
      wdata = $urandom;
      load_en   = ($urandom_range(0, 7) == 0);
      load_addr = (32'($urandom_range(0, Depth + 3)) << 2);
      load_data = $urandom;
      rst   = ($urandom_range(0, 39) != 0);
      tick();
    end
    rd = 1'b0; wr = 1'b0; load_en = 1'b0; rst = 1'b1;
    for (int c = 0; c < 6; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_delayed_ctrl.md
Name: mem_delayed_ctrl

Overview:
- Single-port word memory with fixed, configurable access latency and one outstanding request.
- Sits directly downstream of the processor's memory interface: consumes mem_addr / mem_rd_req / mem_wr_req / mem_wr_data, and returns mem_rd_data / mem_ack / mem_busy.
- Provides a backdoor load port so benches can preload programs and data before releasing reset.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 4, cycles from request acceptance to mem_ack; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of clk.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_rd_req  in  1  read request; single-cycle pulse is sufficient.
- mem_wr_req  in  1  write request; single-cycle pulse is sufficient.
- mem_wr_data  in  32  write data, sampled with mem_wr_req.
- mem_rd_data  out  32  read data; valid in the mem_ack cycle.
- mem_ack  out  1  one-cycle completion pulse for every accepted request.
- mem_busy  out  1  request in flight; new requests are ignored while high.
- load_en  in  1  backdoor write enable.
- load_addr  in  32  backdoor byte address.
- load_data  in  32  backdoor write data.

Behaviour:
Reset (rst==0 at an edge):
- state=IDLE, counter=0, mem_ack=0, mem_busy=0, mem_rd_data=0.
- Memory array contents are not cleared.
- Reset mid-transaction aborts the transaction. No ack is issued. A write already accepted stays committed.

Addressing:
- Word index = mem_addr[31:2].
- Index >= DEPTH is out of range: writes are dropped, reads return 32'h0. Ack timing is unchanged.

Request acceptance:
- A request is accepted on edge T when rst==1, mem_busy==0, and (mem_rd_req | mem_wr_req).
- Acceptance is legal in the IDLE state and in the mem_ack cycle. This supports back-to-back fetches issued combinationally on ack.
- If mem_rd_req and mem_wr_req are both high, the write wins and the read is dropped. Exactly one ack is issued.
- On accepting a write, the array is updated at edge T.
- On accepting a read, the word is captured into an internal holding register at edge T. Later writes do not alter data already in flight.
- Requests presented while mem_busy==1 are ignored silently, with no ack.

States: IDLE -> WAIT -> ACK.
- IDLE: on accept with LATENCY==1, go to ACK; with LATENCY>1, go to WAIT with counter=LATENCY-1.
- WAIT: decrement counter each edge; when the counter reaches 1, go to ACK.
- ACK: on a new accept, go to WAIT or ACK as from IDLE; otherwise go to IDLE.

Output timing:
- mem_ack=1 exactly in cycle T+LATENCY (registered).
- mem_busy=1 in cycles T+1 .. T+LATENCY-1, and is 0 in the ack cycle. With LATENCY==1, mem_busy never asserts.
- mem_rd_data is driven from the holding register in the ack cycle and holds its last value otherwise.
- For write acks, mem_rd_data is unchanged.

Backdoor load:
- load_en writes load_data at index load_addr[31:2] on any edge, including during reset and while busy. Out-of-range indices are dropped.
- If load_en and an accepted write target the same index on the same edge, the processor write wins.

Arithmetic:
- Counter width is 4 bits.
- No state wraps: the counter saturates at 0 and is only reloaded on accept.

Test Plan:
- LATENCY=4: preload word 0 = 32'h00100093, release reset, pulse rd_req addr 0 at cycle 0. Expect busy high cycles 1-3, ack and rd_data=32'h00100093 at cycle 4 only.
- Pulse wr_req addr 8 data 32'hDEADBEEF, then rd_req addr 8 on its ack cycle. Expect the second ack 4 cycles later with 32'hDEADBEEF, and no idle cycle between the transactions.
- Pulse rd_req addr 4 at cycle 2 while busy. Expect no extra ack, and the first transaction completes normally.
- Assert rd_req and wr_req together at addr 12 data 5. Expect a single ack; a subsequent read of addr 12 returns 5.
- Read addr 4*DEPTH. Expect an ack after LATENCY cycles with data 0. Write the same address, then read word 0. Expect word 0 unchanged.
- Drive rst=0 during WAIT. Expect no ack, busy=0 next cycle, and the next request completes with full LATENCY. Repeat with LATENCY=1: expect ack the cycle after the request, with busy never asserted.
